lut_cfg_writer: RTL and testbench

Run-time loader and lookup engine for one LUT neuron whose truth table is written over a word stream, not synthesised as a fixed case ROM. It accepts the packed truth table over a valid/ready configuration port and stores it in distributed RAM. After a complete load it answers lookups with the same address-to-output mapping a compiled neuron gives. It sits beside the generated layer modules so a neuron can be reprogrammed without resynthesis.

---
 rtl/lut_cfg_pkg.sv | 16 +
 rtl/lut_cfg_store.sv | 43 ++++
 rtl/lut_cfg_writer.sv | 82 ++++++++
 tb/tb_lut_cfg_writer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lut_cfg_pkg.sv
// lut_cfg_pkg: shared state type and table geometry helpers for the LUT config writer
package lut_cfg_pkg;
  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;
  function automatic int n_entries(input int in_bits);
    return 1 << in_bits;
  endfunction
  function automatic int total_bits(input int in_bits, input int out_bits);
    return n_entries(in_bits) * out_bits;
  endfunction
  function automatic int n_words(input int in_bits, input int out_bits, input int word_w);
    return (total_bits(in_bits, out_bits) + word_w - 1) / word_w;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lut_cfg_store.sv
// lut_cfg_store: word-written, entry-read distributed RAM holding the packed truth table (readback under LUT_CFG_READBACK_EN)
module lut_cfg_store import lut_cfg_pkg::*; #(
  parameter int IN_BITS = 8,
  parameter int OUT_BITS = 1,
  parameter int WORD_W = 32,
  localparam int NW = n_words(IN_BITS, OUT_BITS, WORD_W),
  localparam int CW = cnt_w(NW)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [CW-1:0]       widx,
  input  logic [WORD_W-1:0]   wdata,
  input  logic                re,
  input  logic [IN_BITS-1:0]  raddr,
`ifdef LUT_CFG_READBACK_EN
  input  logic                rb_re,
  input  logic [CW-1:0]       rb_idx,
  output logic [WORD_W-1:0]   rb_data,
`endif
  output logic [OUT_BITS-1:0] rdata
);
  logic [NW*WORD_W-1:0] mem;
  always_ff @(posedge clk)
    if (we) mem[widx*WORD_W +: WORD_W] <= wdata;
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr*OUT_BITS +: OUT_BITS];
`ifdef LUT_CFG_READBACK_EN
  localparam int TB = total_bits(IN_BITS, OUT_BITS);
  logic [WORD_W-1:0] rb_word;
  // padding bits and out-of-range indices read back as zero
  always_comb begin
    rb_word = '0;
    for (int i = 0; i < WORD_W; i++)
      if (int'(rb_idx) < NW && int'(rb_idx) * WORD_W + i < TB)
        rb_word[i] = mem[int'(rb_idx) * WORD_W + i];
  end
  always_ff @(posedge clk)
    if (rst) rb_data <= '0;
    else if (rb_re) rb_data <= rb_word;
`endif
endmodule

// File: rtl/lut_cfg_writer.sv
// lut_cfg_writer: run-time loader and lookup engine for one LUT neuron (optional readback port: LUT_CFG_READBACK_EN)
module lut_cfg_writer import lut_cfg_pkg::*; #(
  parameter int IN_BITS = 8,
  parameter int OUT_BITS = 1,
  parameter int WORD_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic                cfg_done,
  output logic                busy,
  input  logic [IN_BITS-1:0]  lut_addr,
  input  logic                lut_in_valid,
  output logic [OUT_BITS-1:0] lut_out,
`ifdef LUT_CFG_READBACK_EN
  input  logic                rb_req,
  input  logic [cnt_w(n_words(IN_BITS, OUT_BITS, WORD_W))-1:0] rb_idx,
  output logic [WORD_W-1:0]   rb_data,
  output logic                rb_valid,
`endif
  output logic                lut_out_valid
);
  localparam int NW = n_words(IN_BITS, OUT_BITS, WORD_W);
  localparam int CW = cnt_w(NW);
  state_t state, state_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic we, done_n, re;
  assign cfg_ready = state == LOAD;
  assign busy = state == LOAD;
  assign re = lut_in_valid && state == RUN;
  // a start request always wins, discarding any word offered alongside it
  always_comb begin
    state_n = state;
    wcnt_n = wcnt;
    we = 1'b0;
    done_n = 1'b0;
    if (cfg_start) begin
      state_n = LOAD;
      wcnt_n = '0;
    end else if (state == LOAD && cfg_valid) begin
      we = 1'b1;
      done_n = wcnt == CW'(NW - 1);
      state_n = done_n ? RUN : LOAD;
      wcnt_n = done_n ? wcnt : wcnt + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= EMPTY;
      wcnt <= '0;
      cfg_done <= 1'b0;
      lut_out_valid <= 1'b0;
    end else begin
      state <= state_n;
      wcnt <= wcnt_n;
      cfg_done <= done_n;
      lut_out_valid <= re;
    end
`ifdef LUT_CFG_READBACK_EN
  always_ff @(posedge clk)
    if (rst) rb_valid <= 1'b0;
    else rb_valid <= rb_req && state == RUN;
`endif
  lut_cfg_store #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .WORD_W(WORD_W)) u_store (
    .clk(clk),
    .rst(rst),
    .we(we),
    .widx(wcnt),
    .wdata(cfg_data),
    .re(re),
    .raddr(lut_addr),
`ifdef LUT_CFG_READBACK_EN
    .rb_re(rb_req && state == RUN),
    .rb_idx(rb_idx),
    .rb_data(rb_data),
`endif
    .rdata(lut_out)
  );
endmodule

// File: tb/tb_lut_cfg_writer.sv
// tb_lut_cfg_writer: self-checking bench for lut_cfg_writer against a flat-bit table model
module tb_lut_cfg_writer;
  logic clk = 0, rst = 1, cfg_start = 0, cfg_valid = 0, lut_in_valid = 0;
  logic [31:0] cfg_data = 0;
  logic [7:0] lut_addr = 0;
  logic cfg_ready, cfg_done, busy, lut_out_valid;
  logic [0:0] lut_out;
`ifdef LUT_CFG_READBACK_EN
  logic rb_req = 0, rb_valid;
  logic [2:0] rb_idx = 0;
  logic [31:0] rb_data;
`endif
  int total = 0, bad = 0, done_cnt = 0;
  logic [31:0] words [8];
  typedef struct {logic [7:0] a; logic e;} vec_t;
  vec_t vecs [8];

  lut_cfg_writer dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .busy(busy), .lut_addr(lut_addr),
    .lut_in_valid(lut_in_valid), .lut_out(lut_out),
`ifdef LUT_CFG_READBACK_EN
    .rb_req(rb_req), .rb_idx(rb_idx), .rb_data(rb_data), .rb_valid(rb_valid),
`endif
    .lut_out_valid(lut_out_valid)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (!rst && cfg_done) done_cnt++;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // entry a, output bit j lives at flat bit a*OUT_BITS+j; word = flat/32
  function automatic logic model_bit(input logic [7:0] a);
    int f = int'(a);
    logic [31:0] w = words[f / 32];
    return w[f % 32];
  endfunction

  task automatic send(input logic [31:0] w, input bit probe);
    check("cfg_ready_in_load", {31'b0, cfg_ready}, 1);
    cfg_data = w;
    cfg_valid = 1;
    lut_in_valid = probe;
    tick;
    cfg_valid = 0;
    lut_in_valid = 0;
  endtask

  task automatic load(input logic [31:0] pat [8], input bit gaps);
    int d0;
    cfg_start = 1;
    tick;
    cfg_start = 0;
    d0 = done_cnt;
    for (int k = 0; k < 8; k++) begin
      send(pat[k], k == 7);
      if (gaps && k < 7) begin
        tick;
        check("no_early_done", done_cnt - d0, 0);
      end
    end
    check("done_after_last", {31'b0, cfg_done}, 1);
    check("busy_after_last", {31'b0, busy}, 0);
    check("lookup_in_last_write", {31'b0, lut_out_valid}, 0);
    tick;
    check("done_one_cycle", {31'b0, cfg_done}, 0);
    check("done_pulse_count", done_cnt - d0, 1);
    words = pat;
  endtask

  task automatic lookup(input logic [7:0] a, input bit ev, input logic eo, input string n);
    lut_addr = a;
    lut_in_valid = 1;
    tick;
    lut_in_valid = 0;
    check({n, "_valid"}, {31'b0, lut_out_valid}, {31'b0, ev});
    if (ev) check({n, "_out"}, {31'b0, lut_out}, {31'b0, eo});
  endtask

  initial begin
    logic [31:0] pat [8];
    logic o;
    int d0;
    vecs = '{'{8'h00, 1'b0}, '{8'h07, 1'b1}, '{8'h80, 1'b1}, '{8'hFF, 1'b0},
             '{8'h05, 1'b0}, '{8'h01, 1'b1}, '{8'h3C, 1'b0}, '{8'hA1, 1'b1}};
    tick;
    tick;
    rst = 0;
    check("rst_ready", {31'b0, cfg_ready}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, cfg_done}, 0);
    check("rst_out_valid", {31'b0, lut_out_valid}, 0);
    check("rst_out", {31'b0, lut_out}, 0);
    lookup(8'h05, 0, 0, "empty_lookup");
    for (int k = 0; k < 8; k++) pat[k] = ($countones(k) % 2) ? 32'h69969669 : 32'h96696996;
    for (int g = 0; g < 2; g++) begin
      load(pat, g == 1);
      for (int i = 0; i < 8; i++) lookup(vecs[i].a, 1, vecs[i].e, "parity");
    end
    o = lut_out;
    tick;
    check("hold_valid", {31'b0, lut_out_valid}, 0);
    check("hold_out", {31'b0, lut_out}, {31'b0, o});
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) pat[k] = $urandom;
      lut_addr = 8'($urandom);
      o = model_bit(lut_addr);
      lut_in_valid = 1;
      cfg_start = 1;
      tick;
      lut_in_valid = 0;
      cfg_start = 0;
      check("start_lookup_old_valid", {31'b0, lut_out_valid}, 1);
      check("start_lookup_old_out", {31'b0, lut_out}, {31'b0, o});
      check("start_busy", {31'b0, busy}, 1);
      load(pat, r[0]);
      for (int i = 0; i < 20; i++) begin
        lut_addr = 8'($urandom);
        lookup(lut_addr, 1, model_bit(lut_addr), "rand");
      end
    end
    cfg_start = 1;
    tick;
    cfg_start = 0;
    for (int k = 0; k < 3; k++) send(32'hFFFFFFFF, 0);
    cfg_start = 1;
    cfg_valid = 1;
    cfg_data = 32'hFFFFFFFF;
    tick;
    cfg_start = 0;
    cfg_valid = 0;
    d0 = done_cnt;
    for (int k = 0; k < 7; k++) send(32'h0, 0);
    check("abort_no_early_done", done_cnt - d0, 0);
    check("abort_busy", {31'b0, busy}, 1);
    send(32'h0, 0);
    check("abort_done", {31'b0, cfg_done}, 1);
    for (int a = 0; a < 256; a++) lookup(8'(a), 1, 0, "abort_zero");
    cfg_start = 1;
    tick;
    cfg_start = 0;
    for (int k = 0; k < 5; k++) send(32'h5A5A5A5A, 0);
    d0 = done_cnt;
    rst = 1;
    tick;
    rst = 0;
    check("midrst_ready", {31'b0, cfg_ready}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_done", {31'b0, cfg_done}, 0);
    lookup(8'h10, 0, 0, "midrst_lookup");
    tick;
    check("midrst_no_pulse", done_cnt - d0, 0);
`ifdef LUT_CFG_READBACK_EN
    for (int k = 0; k < 8; k++) pat[k] = 32'h10000000 + k;
    load(pat, 0);
    rb_idx = 5;
    rb_req = 1;
    tick;
    rb_req = 0;
    check("rb_valid", {31'b0, rb_valid}, 1);
    check("rb_data", rb_data, 32'h10000005);
    cfg_start = 1;
    tick;
    cfg_start = 0;
    rb_req = 1;
    tick;
    rb_req = 0;
    check("rb_in_load", {31'b0, rb_valid}, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
